// File: rtl/phase_arbiter_if.sv
// Request/grant bundle between the requesting units and the phase-slot arbiter.
// The arbiter takes the slave side; requesters take the master side.
interface phase_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  owner,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output owner,
    output busy,
    output timeout
  );
endinterface

// File: rtl/phase_arbiter.sv
// Round-robin arbiter for one shared phase slot among 4 requesters.
// One-hot registered grant, bounded hold time, one dead cycle between grants.
module phase_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           reset,
  phase_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       owner_q;
  logic [1:0]       ptr_q;
  logic             busy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hold_q;

  logic             found_d;
  logic [1:0]       win_d;
  logic [1:0]       cand;
  logic             own_done;
  logic             own_req;
  logic             expire;
  logic             release_d;

  // Find the first requester at or after the priority pointer.
  always_comb begin
    found_d = 1'b0;
    win_d   = ptr_q;
    cand    = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (bus.req[cand]) begin
        found_d = 1'b1;
        win_d   = cand;
      end
    end
  end

  assign own_done  = bus.done[owner_q];
  assign own_req   = bus.req[owner_q];
  assign expire    = (hold_q == LAST);
  assign release_d = own_done | ~own_req | expire;

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        GRANT: begin
          if (release_d) begin
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            ptr_q     <= owner_q + 2'd1;
            timeout_q <= own_req & ~own_done;
            state_q   <= GAP;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          if (found_d) begin
            gnt_q   <= 4'b0001 << win_d;
            owner_q <= win_d;
            busy_q  <= 1'b1;
            hold_q  <= '0;
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// Randomized bench for phase_arbiter: two instances (HOLD_MAX 8 and 1)
// share stimulus and are checked every cycle against a grant-level model.
module tb_phase_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;

  int total;
  int bad;

  phase_arbiter_if ifc0 ();
  phase_arbiter_if ifc1 ();

  assign ifc0.req  = req;
  assign ifc0.done = done;
  assign ifc1.req  = req;
  assign ifc1.done = done;

  phase_arbiter #(.HOLD_MAX(8), .CNT_W(4)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc0)
  );

  phase_arbiter #(.HOLD_MAX(1), .CNT_W(4)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who holds the slot (-1 = nobody), how many cycles it has held it,
  // the round-robin start point and the last owner shown on the owner port.
  int m_own  [2];
  int m_held [2];
  int m_ptr  [2];
  int m_last [2];
  bit m_to   [2];
  int hm     [2];

  initial begin
    hm[0] = 8;
    hm[1] = 1;
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mstep(int k);
    int  o;
    int  c;
    bit  hit;
    m_to[k] = 1'b0;
    if (m_own[k] < 0) begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
        c = (m_ptr[k] + i) % 4;
        if (!hit && req[c]) begin
          hit       = 1'b1;
          m_own[k]  = c;
          m_last[k] = c;
          m_held[k] = 1;
        end
      end
    end else begin
      o = m_own[k];
      if (done[o] || !req[o] || m_held[k] == hm[k]) begin
        m_to[k]  = req[o] && !done[o];
        m_ptr[k] = (o + 1) % 4;
        m_own[k] = -1;
      end else begin
        m_held[k]++;
      end
    end
  endtask

  // Advance the model on every clock edge, or clear it on reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k]  = -1;
        m_held[k] = 0;
        m_ptr[k]  = 0;
        m_last[k] = 0;
        m_to[k]   = 1'b0;
      end
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  function automatic int exp_gnt(int k);
    return (m_own[k] >= 0) ? (1 << m_own[k]) : 0;
  endfunction

  task automatic cmp(int k, logic [3:0] g, logic [1:0] ow,
                     logic bz, logic to);
    string p;
    p = (k == 0) ? "h8" : "h1";
    chk({p, ".gnt"},     int'(g),  exp_gnt(k));
    chk({p, ".owner"},   int'(ow), m_last[k]);
    chk({p, ".busy"},    int'(bz), int'(m_own[k] >= 0));
    chk({p, ".timeout"}, int'(to), int'(m_to[k]));
    chk({p, ".onehot0"}, int'($onehot0(g)), 1);
    chk({p, ".busy_or"}, int'(bz), int'(|g));
    chk({p, ".gnt_own"}, int'(g[ow]), int'(bz));
  endtask

  // Compare both instances against the model away from the clock edge.
  always @(negedge clk) begin
    cmp(0, ifc0.gnt, ifc0.owner, ifc0.busy, ifc0.timeout);
    cmp(1, ifc1.gnt, ifc1.owner, ifc1.busy, ifc1.timeout);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req   = 4'b0000;
    done  = 4'b0000;
    repeat (3) tick();
    reset = 1'b0;

    // Idle with no requests.
    repeat (10) tick();
    chk("idle.gnt", int'(ifc0.gnt), 0);

    // Two requesters, no done: grants run to expiry and alternate.
    req = 4'b0101;
    tick();
    chk("p2.h8.first",  int'(ifc0.gnt), 1);
    chk("p2.h1.first",  int'(ifc1.gnt), 1);
    tick();
    chk("p2.h1.gap",    int'(ifc1.gnt), 0);
    chk("p2.h1.to",     int'(ifc1.timeout), 1);
    tick();
    chk("p2.h1.second", int'(ifc1.gnt), 4);
    repeat (5) tick();
    chk("p2.h8.last",   int'(ifc0.gnt), 1);
    chk("p2.h8.lastto", int'(ifc0.timeout), 0);
    tick();
    chk("p2.h8.gap",    int'(ifc0.gnt), 0);
    chk("p2.h8.to",     int'(ifc0.timeout), 1);
    tick();
    chk("p2.h8.second", int'(ifc0.gnt), 4);
    chk("p2.h8.owner",  int'(ifc0.owner), 2);

    // Reset while requester 2 owns the slot.
    reset = 1'b1;
    #1;
    chk("rst.h8.gnt",   int'(ifc0.gnt), 0);
    chk("rst.h8.busy",  int'(ifc0.busy), 0);
    chk("rst.h8.owner", int'(ifc0.owner), 0);
    tick();
    reset = 1'b0;
    req   = 4'b1010;
    tick();
    chk("rst.h8.regnt", int'(ifc0.gnt), 2);
    chk("rst.h1.regnt", int'(ifc1.gnt), 2);

    // All request; the owner releases on its third grant cycle.
    req = 4'b1111;
    repeat (40) begin
      tick();
      if (m_own[0] >= 0 && m_held[0] == 3) done = 4'(1 << m_own[0]);
      else done = 4'b0000;
    end
    done = 4'b0000;

    // Random traffic with slowly changing requests and sparse done strobes.
    repeat (800) begin
      tick();
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      done = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
    end

    req  = 4'b0000;
    done = 4'b0000;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
